// File: rtl/oled_spi_receiver_pkg.sv
// Shared opcodes, decoder state and pending-operation types for the OLED SPI receiver.
package oled_pkg;

  localparam logic [7:0] OP_DISPLAY_OFF = 8'hAE;
  localparam logic [7:0] OP_DISPLAY_ON  = 8'hAF;
  localparam logic [7:0] OP_CONTRAST    = 8'h81;
  localparam logic [7:0] OP_COL_ADDR    = 8'h21;
  localparam logic [7:0] OP_PAGE_ADDR   = 8'h22;
  localparam logic [7:0] CONTRAST_RESET = 8'h7F;

  typedef enum logic [1:0] {D_OPCODE, D_ARG1, D_ARG2} dec_state_e;
  typedef enum logic [1:0] {OPK_CONTRAST, OPK_COL, OPK_PAGE} op_kind_e;

  // Saturate an address argument to the last valid column/page index.
  function automatic logic [7:0] clamp_max(input logic [7:0] value, input logic [7:0] limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/oled_spi_receiver_if.sv
// Display-side SPI link pins: the controller drives them, the receiver samples them.
interface oled_spi_receiver_if;
  logic spi_clk;
  logic spi_mosi;
  logic spi_cs;
  logic oled_dc;
  logic oled_res;

  modport master (output spi_clk, spi_mosi, spi_cs, oled_dc, oled_res);
  modport slave  (input  spi_clk, spi_mosi, spi_cs, oled_dc, oled_res);
endinterface

// File: rtl/oled_spi_receiver_spi_byte_rx.sv
// Synchronizes the SPI pins into clk, detects spi_clk rises and assembles MSB-first bytes.
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  oled_spi_receiver_if.slave         spi,
  output logic                       byte_valid,
  output logic [7:0]                 rx_byte,
  output logic                       byte_dc,
  output logic                       frame_err,
  output logic                       res_n
);

  logic [SYNC_STAGES-1:0] clk_sync, mosi_sync, cs_sync, dc_sync, res_sync;
  logic                   clk_prev, cs_prev;
  logic                   clk_s, mosi_s, cs_s, dc_s;
  logic                   clk_rise, cs_rise;
  logic [7:0]             shift_q;
  logic [2:0]             cnt_q;
  logic                   dc_q, done_q;

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign dc_s     = dc_sync[SYNC_STAGES-1];
  assign res_n    = res_sync[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_prev;
  assign cs_rise  = cs_s & ~cs_prev;

  // The synchronizers keep tracking the pins during oled_res so no false edge appears on release.
  // NOTE: every clocked assignment uses <= so all flops see pre-edge values, as real flops do.
  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_sync  <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      dc_sync   <= '0;
      res_sync  <= '1;
      clk_prev  <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi.spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.spi_mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.spi_cs};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], spi.oled_dc};
      res_sync  <= {res_sync[SYNC_STAGES-2:0], spi.oled_res};
      clk_prev  <= clk_s;
      cs_prev   <= cs_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || !res_n) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      dc_q       <= 1'b0;
      done_q     <= 1'b0;
      byte_valid <= 1'b0;
      rx_byte    <= '0;
      byte_dc    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      byte_valid <= done_q;
      frame_err  <= 1'b0;
      if (done_q) begin
        rx_byte <= shift_q;
        byte_dc <= dc_q;
      end
      if (cs_rise) begin
        frame_err <= (cnt_q != 3'd0);
        cnt_q     <= '0;
      end else if (clk_rise && !cs_s) begin
        shift_q <= {shift_q[6:0], mosi_s};
        cnt_q   <= cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          done_q <= 1'b1;
          dc_q   <= dc_s;
        end
      end
    end
  end

endmodule

// File: rtl/oled_spi_receiver.sv
// OLED command/data decoder: display state, contrast, address windows and frame-buffer writes.
module oled_spi_receiver
  import oled_pkg::*;
#(
  parameter int COLS        = 128,
  parameter int PAGES       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FB_AW       = $clog2(COLS*PAGES)
) (
  input  logic             clk,
  input  logic             reset,
  oled_spi_receiver_if.slave spi,
  output logic             display_on,
  output logic [7:0]       contrast,
  output logic             fb_we,
  output logic [FB_AW-1:0] fb_addr,
  output logic [7:0]       fb_data,
  output logic             cmd_valid,
  output logic [7:0]       cmd_byte,
  output logic             frame_err
);

  localparam logic [7:0] COL_LAST  = 8'(COLS - 1);
  localparam logic [7:0] PAGE_LAST = 8'(PAGES - 1);

  logic       byte_valid, byte_dc, res_n;
  logic [7:0] rx_byte;

  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .spi        (spi),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .byte_dc    (byte_dc),
    .frame_err  (frame_err),
    .res_n      (res_n)
  );

  dec_state_e       state_q, state_d;
  op_kind_e         op_q, op_d;
  logic [7:0]       start_q, start_d;
  logic [7:0]       col_start_q, col_start_d, col_end_q, col_end_d, col_q, col_d;
  logic [7:0]       page_start_q, page_start_d, page_end_q, page_end_d, page_q, page_d;
  logic             display_on_d, fb_we_d, cmd_valid_d;
  logic [7:0]       contrast_d, fb_data_d, cmd_byte_d;
  logic [FB_AW-1:0] fb_addr_d, lin_addr;
  logic [7:0]       arg_limit, arg_clamped, arg_end;

  // NOTE: every signal gets its default up front so no path through the case leaves a latch.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    start_d      = start_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    col_d        = col_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    page_d       = page_q;
    display_on_d = display_on;
    contrast_d   = contrast;
    fb_we_d      = 1'b0;
    fb_addr_d    = fb_addr;
    fb_data_d    = fb_data;
    cmd_valid_d  = 1'b0;
    cmd_byte_d   = cmd_byte;
    arg_limit    = (op_q == OPK_COL) ? COL_LAST : PAGE_LAST;
    arg_clamped  = clamp_max(rx_byte, arg_limit);
    arg_end      = (arg_clamped < start_q) ? start_q : arg_clamped;
    lin_addr     = FB_AW'(page_q) * FB_AW'(COLS) + FB_AW'(col_q);

    if (byte_valid && byte_dc) begin
      // A data byte always lands in the frame buffer and cancels any half-received command.
      fb_we_d   = 1'b1;
      fb_data_d = rx_byte;
      fb_addr_d = lin_addr;
      state_d   = D_OPCODE;
      if (col_q < col_end_q) begin
        col_d = col_q + 8'd1;
      end else begin
        col_d  = col_start_q;
        page_d = (page_q < page_end_q) ? page_q + 8'd1 : page_start_q;
      end
    end else if (byte_valid) begin
      cmd_valid_d = 1'b1;
      cmd_byte_d  = rx_byte;
      case (state_q)
        D_OPCODE: begin
          case (rx_byte)
            OP_DISPLAY_OFF: display_on_d = 1'b0;
            OP_DISPLAY_ON:  display_on_d = 1'b1;
            OP_CONTRAST:  begin op_d = OPK_CONTRAST; state_d = D_ARG1; end
            OP_COL_ADDR:  begin op_d = OPK_COL;      state_d = D_ARG1; end
            OP_PAGE_ADDR: begin op_d = OPK_PAGE;     state_d = D_ARG1; end
            default: ;
          endcase
        end
        D_ARG1: begin
          if (op_q == OPK_CONTRAST) begin
            contrast_d = rx_byte;
            state_d    = D_OPCODE;
          end else begin
            start_d = arg_clamped;
            state_d = D_ARG2;
          end
        end
        D_ARG2: begin
          if (op_q == OPK_COL) begin
            col_start_d = start_q;
            col_end_d   = arg_end;
            col_d       = start_q;
          end else begin
            page_start_d = start_q;
            page_end_d   = arg_end;
            page_d       = start_q;
          end
          state_d = D_OPCODE;
        end
        default: state_d = D_OPCODE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || !res_n) begin
      state_q      <= D_OPCODE;
      op_q         <= OPK_CONTRAST;
      start_q      <= '0;
      col_start_q  <= '0;
      col_end_q    <= COL_LAST;
      col_q        <= '0;
      page_start_q <= '0;
      page_end_q   <= PAGE_LAST;
      page_q       <= '0;
      display_on   <= 1'b0;
      contrast     <= CONTRAST_RESET;
      fb_we        <= 1'b0;
      fb_addr      <= '0;
      fb_data      <= '0;
      cmd_valid    <= 1'b0;
      cmd_byte     <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      start_q      <= start_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      col_q        <= col_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      page_q       <= page_d;
      display_on   <= display_on_d;
      contrast     <= contrast_d;
      fb_we        <= fb_we_d;
      fb_addr      <= fb_addr_d;
      fb_data      <= fb_data_d;
      cmd_valid    <= cmd_valid_d;
      cmd_byte     <= cmd_byte_d;
    end
  end

endmodule

// File: tb/tb_oled_spi_receiver.sv
// Randomized bench for oled_spi_receiver: bytes are bit-banged over SPI and compared to a panel model.
`timescale 1ns/1ps
module tb_oled_spi_receiver;

  localparam int COLS        = 128;
  localparam int PAGES       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int FB_AW       = $clog2(COLS*PAGES);
  // Edges from the 8th spi_clk rise to the strobe: synchronizer, edge register, byte strobe, output.
  localparam int LATENCY     = SYNC_STAGES + 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             display_on, fb_we, cmd_valid, frame_err;
  logic [7:0]       contrast, fb_data, cmd_byte;
  logic [FB_AW-1:0] fb_addr;

  oled_spi_receiver_if spi_if ();

  oled_spi_receiver #(.COLS(COLS), .PAGES(PAGES), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk        (clk),
    .reset      (reset),
    .spi        (spi_if.slave),
    .display_on (display_on),
    .contrast   (contrast),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .cmd_valid  (cmd_valid),
    .cmd_byte   (cmd_byte),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Strobe monitor: every fb_we/cmd_valid cycle is logged with a timestamp.
  typedef struct {
    int   cyc;
    bit   is_data;
    bit   both;
    int   addr;
    int   data;
    int   on;
    int   contrast;
  } ev_t;

  ev_t ev_q[$];
  int  cyc = 0;
  int  fe_cnt = 0;
  int  rise_cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (fb_we || cmd_valid) begin
      ev_t e;
      e.cyc      = cyc;
      e.is_data  = fb_we;
      e.both     = fb_we && cmd_valid;
      e.addr     = int'(fb_addr);
      e.data     = fb_we ? int'(fb_data) : int'(cmd_byte);
      e.on       = int'(display_on);
      e.contrast = int'(contrast);
      ev_q.push_back(e);
    end
    if (frame_err) fe_cnt++;
  end

  // Panel model kept as plain integers.
  int m_on, m_contrast, m_cs, m_ce, m_ps, m_pe, m_col, m_page;
  int m_pending;   // 0: none, else the opcode awaiting arguments
  int m_args_seen;
  int m_start;

  function automatic int min_i(input int a, input int b); return (a < b) ? a : b; endfunction
  function automatic int max_i(input int a, input int b); return (a > b) ? a : b; endfunction

  task automatic model_reset();
    m_on = 0; m_contrast = 'h7F;
    m_cs = 0; m_ce = COLS - 1; m_ps = 0; m_pe = PAGES - 1;
    m_col = 0; m_page = 0;
    m_pending = 0; m_args_seen = 0; m_start = 0;
  endtask

  // Applies one byte to the model, returns the expected frame-buffer address for data bytes.
  task automatic model_byte(input bit dc, input int b, output int exp_addr);
    int lim;
    exp_addr = 0;
    if (dc) begin
      exp_addr = m_page * COLS + m_col;
      if (m_col < m_ce) m_col++;
      else begin
        m_col  = m_cs;
        m_page = (m_page < m_pe) ? m_page + 1 : m_ps;
      end
      m_pending = 0;
    end else if (m_pending == 0) begin
      if (b == 'hAE) m_on = 0;
      else if (b == 'hAF) m_on = 1;
      else if (b == 'h81 || b == 'h21 || b == 'h22) begin
        m_pending = b; m_args_seen = 0;
      end
    end else begin
      lim = (m_pending == 'h21) ? COLS : PAGES;
      if (m_pending == 'h81) begin
        m_contrast = b; m_pending = 0;
      end else if (m_args_seen == 0) begin
        m_start = min_i(b, lim - 1); m_args_seen = 1;
      end else begin
        if (m_pending == 'h21) begin
          m_cs = m_start; m_ce = max_i(min_i(b, lim - 1), m_start); m_col = m_start;
        end else begin
          m_ps = m_start; m_pe = max_i(min_i(b, lim - 1), m_start); m_page = m_start;
        end
        m_pending = 0;
      end
    end
  endtask

  // Bit-bangs nbits of b (MSB first) in SPI mode 0; each spi_clk level lasts `half` clk cycles.
  task automatic send_bits(input bit dc, input logic [7:0] b, input int nbits, input int half);
    @(negedge clk);
    spi_if.spi_cs  = 1'b0;
    spi_if.oled_dc = dc;
    repeat (half) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_if.spi_mosi = b[7-i];
      repeat (half) @(negedge clk);
      spi_if.spi_clk = 1'b1;
      if (i == 7) rise_cyc = cyc;
      repeat (half) @(negedge clk);
      spi_if.spi_clk = 1'b0;
    end
    repeat (half) @(negedge clk);
    spi_if.spi_cs = 1'b1;
    repeat (half + 2) @(negedge clk);
  endtask

  // Sends one complete byte and checks the single strobe it must produce.
  task automatic send_and_check(input bit dc, input int b, input int half);
    int exp_addr;
    ev_t e;
    send_bits(dc, 8'(b), 8, half);
    model_byte(dc, b, exp_addr);
    check($sformatf("strobe_count_%s_%02h", dc ? "data" : "cmd", b), ev_q.size(), 1);
    if (ev_q.size() > 0) begin
      e = ev_q.pop_front();
      check("strobe_latency", e.cyc - rise_cyc, LATENCY);
      check("strobe_kind", int'(e.is_data), int'(dc));
      check("strobe_exclusive", int'(e.both), 0);
      check(dc ? "fb_data" : "cmd_byte", e.data, b);
      if (dc) check("fb_addr", e.addr, exp_addr);
      check("display_on", e.on, m_on);
      check("contrast", e.contrast, m_contrast);
    end
    ev_q.delete();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_display_on"}, int'(display_on), 0);
    check({pfx, "_contrast"},   int'(contrast), 'h7F);
    check({pfx, "_fb_we"},      int'(fb_we), 0);
    check({pfx, "_fb_addr"},    int'(fb_addr), 0);
    check({pfx, "_fb_data"},    int'(fb_data), 0);
    check({pfx, "_cmd_valid"},  int'(cmd_valid), 0);
    check({pfx, "_cmd_byte"},   int'(cmd_byte), 0);
    check({pfx, "_frame_err"},  int'(frame_err), 0);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int r, half, fe_before;
    spi_if.spi_clk  = 1'b0;
    spi_if.spi_mosi = 1'b0;
    spi_if.spi_cs   = 1'b1;
    spi_if.oled_dc  = 1'b0;
    spi_if.oled_res = 1'b1;
    reset = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");

    // Pending contrast command abandoned by a data byte.
    send_and_check(1'b0, 'h81, 4);
    send_and_check(1'b1, 'h55, 4);

    send_and_check(1'b0, 'hAF, 4);
    send_and_check(1'b0, 'hAE, 4);
    send_and_check(1'b0, 'h81, 4);
    send_and_check(1'b0, 'h3C, 4);

    // Window 124..127 x 2..3, then wrap across pages and back.
    send_and_check(1'b0, 'h21, 4); send_and_check(1'b0, 'h7C, 4); send_and_check(1'b0, 'h7F, 4);
    send_and_check(1'b0, 'h22, 4); send_and_check(1'b0, 'h02, 4); send_and_check(1'b0, 'h03, 4);
    for (int i = 0; i < 9; i++) send_and_check(1'b1, $urandom_range(0, 255), 4);

    // Out-of-range column arguments clamp to 127..127.
    send_and_check(1'b0, 'h21, 4); send_and_check(1'b0, 'h90, 4); send_and_check(1'b0, 'h10, 4);
    for (int i = 0; i < 3; i++) send_and_check(1'b1, $urandom_range(0, 255), 4);

    // Partial byte then a full one.
    fe_before = fe_cnt;
    send_bits(1'b0, 8'hA5, 5, 4);
    check("frame_err_pulses", fe_cnt - fe_before, 1);
    check("frame_err_no_strobe", ev_q.size(), 0);
    ev_q.delete();
    send_and_check(1'b0, 'hAF, 4);

    // Randomized traffic with a random spi_clk divider.
    for (int n = 0; n < 40; n++) begin
      half = $urandom_range(SYNC_STAGES + 1, 6);
      r = $urandom_range(0, 9);
      case (r)
        5: send_and_check(1'b0, ($urandom_range(0, 1) != 0) ? 'hAF : 'hAE, half);
        6: begin send_and_check(1'b0, 'h81, half); send_and_check(1'b0, $urandom_range(0, 255), half); end
        7: begin
          send_and_check(1'b0, 'h21, half);
          send_and_check(1'b0, $urandom_range(0, 255), half);
          send_and_check(1'b0, $urandom_range(0, 255), half);
        end
        8: begin
          send_and_check(1'b0, 'h22, half);
          send_and_check(1'b0, $urandom_range(0, 7), half);
          send_and_check(1'b0, $urandom_range(0, 7), half);
        end
        9: send_and_check(1'b0, $urandom_range(0, 255), half);
        default: send_and_check(1'b1, $urandom_range(0, 255), half);
      endcase
    end

    // oled_res pulsed low in the middle of a byte.
    send_and_check(1'b0, 'hAF, 4);
    send_and_check(1'b0, 'h81, 4);
    send_and_check(1'b0, 'h20, 4);
    fe_before = fe_cnt;
    @(negedge clk);
    spi_if.spi_cs  = 1'b0;
    spi_if.oled_dc = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      spi_if.spi_mosi = 1'b1;
      repeat (4) @(negedge clk);
      spi_if.spi_clk = 1'b1;
      repeat (4) @(negedge clk);
      spi_if.spi_clk = 1'b0;
    end
    spi_if.oled_res = 1'b0;
    repeat (8) @(negedge clk);
    spi_if.spi_cs = 1'b1;
    repeat (8) @(negedge clk);
    check_reset_outputs("oled_res");
    spi_if.oled_res = 1'b1;
    repeat (6) @(negedge clk);
    model_reset();
    check_reset_outputs("after_res");
    check("res_no_strobe", ev_q.size(), 0);
    check("res_no_frame_err", fe_cnt - fe_before, 0);
    ev_q.delete();
    send_and_check(1'b1, 'hC3, 4);
    send_and_check(1'b1, 'h3C, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/oled_spi_receiver.md
Name: oled_spi_receiver

Overview:
SPI-slave end of the OLED command/data link: samples the display-side SPI pins (spi_clk, spi_mosi, spi_cs, oled_dc, oled_res) in the system clock domain and assembles bytes. It decodes the command stream: display on/off, contrast, and column/page address windows. Data bytes become pixel-page writes to an external frame buffer with horizontal auto-increment addressing. It serves as the display model for the OLED controller in simulation and as an on-FPGA display emulator.

Parameters:
COLS, 128, display columns
PAGES, 4, 8-pixel-high pages (128x32 panel)
SYNC_STAGES, 2, synchronizer depth on every SPI/control input (>=2)
FB_AW, $clog2(COLS*PAGES), frame-buffer address width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
spi_clk  in  1  SPI clock from master, async to clk, mode 0
spi_mosi  in  1  serial data, MSB first
spi_cs  in  1  chip select, active low
oled_dc  in  1  0 = command byte, 1 = data byte
oled_res  in  1  display reset, active low
display_on  out  1  1 after 0xAF, 0 after 0xAE
contrast  out  8  last 0x81 argument
fb_we  out  1  one-cycle frame-buffer write strobe
fb_addr  out  FB_AW  page*COLS + column
fb_data  out  8  data byte (one column of one page)
cmd_valid  out  1  one-cycle strobe for every command byte (opcodes and arguments)
cmd_byte  out  8  the command byte, valid with cmd_valid
frame_err  out  1  one-cycle pulse: cs deasserted with 1..7 bits pending

Behaviour:
- Reset (reset==0 at posedge clk): display_on=0, contrast=8'h7F, fb_we=0, fb_addr=0, fb_data=0, cmd_valid=0, cmd_byte=0, frame_err=0. Column window is 0..COLS-1 and page window is 0..PAGES-1. Column and page pointers are 0. Bit counter is 0. Decoder state is D_OPCODE. Synchronizers flush to idle (cs=1, clk=0).
- oled_res synchronized low: same effect as reset on all registers and outputs. While low, all SPI traffic is ignored.
- Inputs pass through SYNC_STAGES flops. A rising edge is detected from the last two synchronized spi_clk samples. The master must hold each spi_clk level for >=SYNC_STAGES+1 clk cycles.
- Bit capture: on a detected rising edge with synced cs==0, shift mosi into an 8-bit register and increment the bit counter. On the 8th bit, latch synced dc, produce the internal byte strobe in the next cycle, and clear the counter.
- cs rising edge with counter in 1..7: discard the partial byte, clear the counter, pulse frame_err. With counter==0: no effect. The decoder state is NOT reset by cs.
- Latency: fb_we, or cmd_valid with decoder updates, is asserted exactly 2 clk cycles after the clk edge that detects the 8th spi_clk rise.
- Data byte (dc=1): fb_we=1, fb_data=byte, fb_addr=page*COLS+col. The pointers then advance:
  - col<col_end: col++.
  - col==col_end: col=col_start, then page++ if page<page_end, else page=page_start.
  - If the decoder is in D_ARG1 or D_ARG2, the pending command is abandoned (state goes to D_OPCODE) and the byte is still written.
- Command byte (dc=0): cmd_valid=1, cmd_byte=byte. Decoder FSM:
  - D_OPCODE:
    - 8'hAE: display_on=0.
    - 8'hAF: display_on=1.
    - 8'h81: go to D_ARG1 with op=contrast.
    - 8'h21: go to D_ARG1 with op=column.
    - 8'h22: go to D_ARG1 with op=page.
    - Any other opcode: no effect besides the cmd_valid strobe.
  - D_ARG1:
    - contrast: contrast=byte, go to D_OPCODE.
    - column/page: store start = min(byte, max-1), go to D_ARG2.
  - D_ARG2: end = max(min(byte, max-1), start). Load the window (col_start/col_end or page_start/page_end). Set the matching pointer to start. Go to D_OPCODE.
  - max is COLS for column and PAGES for page.
- Width rules: pointer compares are done at byte width before clamping. fb_addr is computed with FB_AW bits and never exceeds COLS*PAGES-1.
- Simultaneous reset and byte strobe: reset wins.

Decomposition:
- Package oled_pkg: opcodes OP_DISPLAY_OFF=8'hAE, OP_DISPLAY_ON=8'hAF, OP_CONTRAST=8'h81, OP_COL_ADDR=8'h21, OP_PAGE_ADDR=8'h22, CONTRAST_RESET=8'h7F. Also the decoder state enum {D_OPCODE, D_ARG1, D_ARG2} and the pending-op enum {OPK_CONTRAST, OPK_COL, OPK_PAGE}.
- Sub-module spi_byte_rx: synchronizers, edge detect, shift register, bit counter, and frame_err. Outputs byte_valid, byte, and byte_dc.
- The top level holds the decoder FSM, the address pointers, and the output registers.

Test Plan:
- After reset, send command 0xAF (dc=0) at a divider of 4 -> cmd_valid with cmd_byte=8'hAF; display_on=1 exactly 2 clk after the 8th rise. Then send 0xAE -> display_on=0.
- Send 0x81, then 0x3C -> contrast=8'h3C; two cmd_valid pulses; no fb_we.
- Send 0x21,0x7C,0x7F and 0x22,0x02,0x03, then 6 data bytes D0..D5 -> fb_addr sequence 380,381,382,383,508,509 with fb_data=D0..D5. Next 2 bytes wrap to page 2 (addresses 510,511, then 380).
- Send 0x21,0x90,0x10 -> window clamps to 127..127. The next data writes go to col 127 only.
- Drop cs after 5 bits -> frame_err pulses once, no strobes. A following full byte 0xAF decodes correctly.
- Mid-command: send 0x81, then a data byte 0x55 -> fb_we at addr 0 with data 0x55; contrast stays 8'h7F. Pulse oled_res low mid-byte -> all outputs return to reset values.
